// File: rtl/tone_synth_if.sv
// Note-command handshake into tone_synth.
// Upstream offers one note; the synth takes it when ready.
interface tone_synth_if #(
  parameter int HP_W  = 16,
  parameter int DUR_W = 12
);
  logic             note_valid;
  logic [HP_W-1:0]  note_half_period;
  logic [DUR_W-1:0] note_dur_ms;
  logic             note_ready;

  modport master (
    output note_valid,
    output note_half_period,
    output note_dur_ms,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_half_period,
    input  note_dur_ms,
    output note_ready
  );
endinterface

// File: rtl/tone_synth.sv
// Square-wave note player with a one-entry note slot
// and a silent articulation gap after every note.
module tone_synth #(
  parameter int GAP_MS = 10,
  parameter int HP_W   = 16,
  parameter int DUR_W  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ticks_per_milli,
  tone_synth_if.slave note_if,
  output logic        sound,
  output logic        playing,
  output logic        note_done
);

  localparam int GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_e;

  state_e             state_q;
  logic               pend_full_q;
  logic [HP_W-1:0]    pend_hp_q;
  logic [DUR_W-1:0]   pend_dur_q;
  logic [HP_W-1:0]    act_hp_q;
  logic [DUR_W-1:0]   act_dur_q;
  logic [15:0]        tpm_q;
  logic [15:0]        ms_cnt_q;
  logic [HP_W-1:0]    hp_cnt_q;
  logic [DUR_W-1:0]   dur_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               sound_q;
  logic               playing_q;
  logic               done_q;

  logic               ready;
  logic               accept;
  logic               ms_tick;
  logic               hp_wrap;
  logic               note_end;
  logic               gap_end;
  logic               leave;
  logic               load;
  logic [15:0]        tpm_d;

  assign ready   = rst_n & ~pend_full_q;
  assign accept  = note_if.note_valid & ready;

  assign note_if.note_ready = ready;
  assign sound     = sound_q;
  assign playing   = playing_q;
  assign note_done = done_q;

  always_comb begin
    ms_tick  = (ms_cnt_q == tpm_q - 16'd1);
    hp_wrap  = (hp_cnt_q == act_hp_q - HP_W'(1));
    note_end = 1'b0;
    gap_end  = 1'b0;
    if (state_q == PLAY) begin
      note_end = (act_dur_q == '0) ||
                 (ms_tick &&
                  dur_cnt_q == act_dur_q - DUR_W'(1));
    end
    if (state_q == GAP) begin
      gap_end = ms_tick && (gap_cnt_q == GAP_LAST);
    end
    // With no gap configured a finished note exits at once
    leave = gap_end || (note_end && (GAP_MS == 0));
    load  = pend_full_q && ((state_q == IDLE) || leave);
    tpm_d = (ticks_per_milli == 16'd0) ? 16'd1
                                       : ticks_per_milli;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_hp_q   <= '0;
      pend_dur_q  <= '0;
    end else if (accept) begin
      pend_full_q <= 1'b1;
      pend_hp_q   <= note_if.note_half_period;
      pend_dur_q  <= note_if.note_dur_ms;
    end else if (load) begin
      pend_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_hp_q  <= '0;
      act_dur_q <= '0;
      tpm_q     <= '0;
      ms_cnt_q  <= '0;
      hp_cnt_q  <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      sound_q   <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= note_end;
      if (load) begin
        state_q   <= PLAY;
        playing_q <= 1'b1;
        act_hp_q  <= pend_hp_q;
        act_dur_q <= pend_dur_q;
        tpm_q     <= tpm_d;
        ms_cnt_q  <= '0;
        hp_cnt_q  <= '0;
        dur_cnt_q <= '0;
        gap_cnt_q <= '0;
        sound_q   <= 1'b0;
      end else begin
        unique case (state_q)
          PLAY: begin
            if (note_end) begin
              state_q   <= (GAP_MS == 0) ? IDLE : GAP;
              playing_q <= 1'b0;
              sound_q   <= 1'b0;
              ms_cnt_q  <= '0;
              gap_cnt_q <= '0;
            end else begin
              ms_cnt_q <= ms_tick ? 16'd0
                                  : ms_cnt_q + 16'd1;
              if (ms_tick) begin
                dur_cnt_q <= dur_cnt_q + DUR_W'(1);
              end
              unique case (1'b1)
                (act_hp_q == '0): begin
                  sound_q <= 1'b0;
                end
                hp_wrap: begin
                  hp_cnt_q <= '0;
                  sound_q  <= ~sound_q;
                end
                default: begin
                  hp_cnt_q <= hp_cnt_q + HP_W'(1);
                end
              endcase
            end
          end
          GAP: begin
            sound_q <= 1'b0;
            if (gap_end) begin
              state_q <= IDLE;
            end else begin
              ms_cnt_q <= ms_tick ? 16'd0
                                  : ms_cnt_q + 16'd1;
              if (ms_tick) begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
              end
            end
          end
          default: begin
            sound_q   <= 1'b0;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Randomised and directed bench for tone_synth against
// a timeline model of note start, length and gap.
module tb_tone_synth;
  localparam int GAP_MS = 10;
  localparam int HP_W   = 16;
  localparam int DUR_W  = 12;

  typedef struct {
    int hp;
    int dur;
  } note_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ticks_per_milli;
  logic        sound;
  logic        playing;
  logic        note_done;

  tone_synth_if #(.HP_W(HP_W), .DUR_W(DUR_W)) nif ();

  tone_synth #(
    .GAP_MS(GAP_MS),
    .HP_W  (HP_W),
    .DUR_W (DUR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ticks_per_milli(ticks_per_milli),
    .note_if        (nif),
    .sound          (sound),
    .playing        (playing),
    .note_done      (note_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  note_t tx_q[$];
  int    idle_gap = 0;
  bit    rnd_tk = 0;

  longint n_e = 0;
  bit     pend_has = 0;
  int     p_hp, p_dur;
  bit     has_cur = 0;
  longint cur_l, cur_p, free_e = 0;
  int     cur_hp;
  bit     acc_m;

  int     m_play, m_tog, m_done, m_stall;
  longint d_q[$];
  longint r_q[$];
  int     rdy_q[$];
  logic   last_snd = 1'b0;
  logic   last_play = 1'b0;

  task automatic chk(string tag, longint obs, longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int tkl;
    n_e++;
    acc_m = 0;
    if (!rst_n) begin
      pend_has = 0;
      has_cur  = 0;
      free_e   = 0;
      return;
    end
    acc_m = nif.note_valid && !pend_has;
    if (pend_has && n_e >= free_e) begin
      tkl     = (ticks_per_milli == 0) ? 1 : int'(ticks_per_milli);
      has_cur = 1;
      cur_l   = n_e;
      cur_hp  = p_hp;
      cur_p   = (p_dur == 0) ? 1 : longint'(p_dur) * tkl;
      free_e  = cur_l + cur_p + longint'(GAP_MS) * tkl;
      pend_has = 0;
    end
    if (acc_m) begin
      pend_has = 1;
      p_hp  = int'(nif.note_half_period);
      p_dur = int'(nif.note_dur_ms);
    end
  endtask

  task automatic drive();
    if (rnd_tk && $urandom_range(0, 3) == 0)
      ticks_per_milli = 16'($urandom_range(0, 6));
    if (tx_q.size() != 0 && idle_gap == 0) begin
      nif.note_valid       = 1'b1;
      nif.note_half_period = HP_W'(tx_q[0].hp);
      nif.note_dur_ms      = DUR_W'(tx_q[0].dur);
    end else begin
      nif.note_valid       = 1'b0;
      nif.note_half_period = HP_W'($urandom);
      nif.note_dur_ms      = DUR_W'($urandom);
      if (idle_gap > 0) idle_gap--;
    end
  endtask

  task automatic step();
    bit e_play, e_snd, e_done, e_rdy;
    @(posedge clk);
    model_edge();
    if (acc_m) begin
      void'(tx_q.pop_front());
      if (rnd_tk) idle_gap = $urandom_range(0, 3);
    end
    @(negedge clk);
    e_play = has_cur && n_e >= cur_l && n_e < cur_l + cur_p;
    e_snd  = e_play && cur_hp != 0 &&
             (((n_e - cur_l) / cur_hp) % 2 == 1);
    e_done = has_cur && n_e == cur_l + cur_p;
    e_rdy  = rst_n && !pend_has;
    chk("playing", playing, e_play);
    chk("sound", sound, e_snd);
    chk("note_done", note_done, e_done);
    chk("note_ready", nif.note_ready, e_rdy);
    if (playing) m_play++;
    if (sound != last_snd) m_tog++;
    if (note_done) begin
      m_done++;
      d_q.push_back(n_e);
    end
    if (playing && !last_play) begin
      r_q.push_back(n_e);
      rdy_q.push_back(int'(nif.note_ready));
    end
    if (nif.note_valid && !nif.note_ready) m_stall++;
    last_snd  = sound;
    last_play = playing;
    drive();
  endtask

  task automatic clr_meas();
    m_play = 0;
    m_tog = 0;
    m_done = 0;
    m_stall = 0;
    d_q.delete();
    r_q.delete();
    rdy_q.delete();
  endtask

  task automatic run_idle(int limit);
    int k = 0;
    while (!(tx_q.size() == 0 && !pend_has && n_e >= free_e)
           && k < limit) begin
      step();
      k++;
    end
    chk("idle_timeout", int'(k < limit), 1);
    step();
  endtask

  initial begin
    nif.note_valid       = 1'b0;
    nif.note_half_period = '0;
    nif.note_dur_ms      = '0;
    ticks_per_milli      = 16'd100;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", nif.note_ready, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", nif.note_ready, 1);

    clr_meas();
    tx_q.push_back('{50, 3});
    run_idle(3000);
    chk("basic_play", m_play, 300);
    chk("basic_toggles", m_tog, 6);
    chk("basic_done", m_done, 1);
    chk("basic_snd_end", sound, 0);

    clr_meas();
    tx_q.push_back('{0, 2});
    run_idle(3000);
    chk("rest_play", m_play, 200);
    chk("rest_toggles", m_tog, 0);
    chk("rest_done", m_done, 1);

    clr_meas();
    tx_q.push_back('{25, 2});
    tx_q.push_back('{40, 1});
    run_idle(5000);
    chk("b2b_starts", r_q.size(), 2);
    chk("b2b_dones", d_q.size(), 2);
    if (r_q.size() >= 2 && d_q.size() >= 1) begin
      chk("b2b_gap", r_q[1] - d_q[0], 1000);
      chk("b2b_rdy_first", rdy_q[0], 1);
    end

    clr_meas();
    ticks_per_milli = 16'd3;
    tx_q.push_back('{2, 2});
    tx_q.push_back('{3, 1});
    tx_q.push_back('{0, 1});
    run_idle(2000);
    chk("bp_stall", int'(m_stall > 0), 1);
    chk("bp_starts", r_q.size(), 3);
    chk("bp_dones", m_done, 3);
    chk("bp_play", m_play, 12);

    clr_meas();
    ticks_per_milli = 16'd5;
    tx_q.push_back('{3, 0});
    run_idle(500);
    chk("dur0_play", m_play, 1);
    chk("dur0_done", m_done, 1);

    clr_meas();
    ticks_per_milli = 16'd0;
    tx_q.push_back('{1, 4});
    run_idle(500);
    chk("tk0_play", m_play, 4);
    chk("tk0_toggles", m_tog, 4);
    chk("tk0_done", m_done, 1);

    clr_meas();
    ticks_per_milli = 16'd10;
    tx_q.push_back('{3, 5});
    tx_q.push_back('{4, 2});
    begin
      int k = 0;
      while (m_play < 20 && k < 500) begin
        step();
        k++;
      end
      chk("rst_mid_reach", int'(k < 500), 1);
    end
    rst_n = 1'b0;
    tx_q.delete();
    nif.note_valid = 1'b0;
    step();
    chk("rst_mid_sound", sound, 0);
    rst_n = 1'b1;
    clr_meas();
    repeat (200) step();
    chk("rst_mid_done", m_done, 0);
    chk("rst_mid_play", m_play, 0);
    chk("rst_mid_ready", nif.note_ready, 1);

    clr_meas();
    rnd_tk = 1;
    for (int i = 0; i < 40; i++)
      tx_q.push_back('{$urandom_range(0, 7),
                      $urandom_range(0, 5)});
    run_idle(20000);
    rnd_tk = 0;
    chk("rnd_dones", m_done, 40);
    chk("rnd_starts", r_q.size(), 40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 SHALL have parameter GAP_MS, default 10: silent articulation gap after each note, in ms; 0 means no gap.
REQ-002 SHALL have parameter HP_W, default 16: width of the half-period field and of its counter.
REQ-003 SHALL have parameter DUR_W, default 12: width of the duration field and of its counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port ticks_per_milli, input, 16: clk cycles per millisecond.
REQ-007 SHALL have port note_valid, input, 1: upstream note command is present.
REQ-008 SHALL have port note_half_period, input, HP_W: tone half-period in clk cycles; 0 means a rest.
REQ-009 SHALL have port note_dur_ms, input, DUR_W: note duration in ms.
REQ-010 SHALL have port note_ready, output, 1: the pending slot is free.
REQ-011 SHALL have port sound, output, 1: square-wave speaker drive.
REQ-012 SHALL have port playing, output, 1: high in state PLAY.
REQ-013 SHALL have port note_done, output, 1: one-cycle pulse when a note ends.

Function
REQ-014 SHALL contain a one-entry pending register holding {half_period, dur_ms}; note_ready = !pending_full.
REQ-015 SHALL accept a note on a clock edge where note_valid && note_ready; while note_valid && !note_ready, upstream holds the fields stable.
REQ-016 SHALL implement FSM states IDLE, PLAY and GAP; the reset state is IDLE.
REQ-017 SHALL, in IDLE with pending_full, on the next edge move the note to the active registers, clear pending_full, enter PLAY, and reset the ms, half-period and duration counters.
REQ-018 SHALL latch ticks_per_milli at note load; a value of 0 SHALL be treated as 1; later input changes SHALL not affect the active note.
REQ-019 SHALL, in PLAY, increment the ms counter every cycle and wrap it at latched_ticks-1; each wrap SHALL be one ms tick.
REQ-020 SHALL, in PLAY with half_period != 0, toggle sound each time the half-period counter wraps at half_period-1; the first toggle SHALL occur half_period cycles after PLAY entry.
REQ-021 SHALL hold sound at 0 throughout PLAY when half_period == 0 (rest).
REQ-022 SHALL end the note on the ms tick that completes dur_ms ms, so PLAY lasts exactly dur_ms × latched_ticks cycles.
REQ-023 SHALL, when dur_ms == 0, stay in PLAY for exactly 1 cycle with sound held at 0.
REQ-024 SHALL, on note end, pulse note_done for 1 cycle, force sound to 0 on the same edge, and enter GAP; if GAP_MS == 0 it SHALL behave as the GAP-exit rule immediately.
REQ-025 SHALL, in GAP, hold sound at 0 for GAP_MS ms counted with the latched tick value.
REQ-026 SHALL, on GAP exit, enter PLAY directly if pending_full (loading as in REQ-017), else IDLE.
REQ-027 SHALL allow a note accepted while in PLAY or GAP to wait in the pending slot; that note SHALL be neither lost nor started early.
REQ-028 SHALL, when an accept and a pending-to-active load occur on the same edge, perform both: the slot is refilled with the new note and the old note goes active.
REQ-029 SHALL saturate no counter: all counters wrap as stated, and duration counting SHALL use DUR_W bits with no overflow for the maximum dur_ms.

Reset
REQ-030 SHALL, while rst_n == 0 at a clock edge, set state = IDLE, pending_full = 0, all counters = 0, sound = 0, playing = 0 and note_done = 0.
REQ-031 SHALL hold note_ready at 0 during reset and at 1 from the first cycle after rst_n returns high.
REQ-032 SHALL, on reset during PLAY or GAP, discard both the active note and the pending note; sound SHALL be 0 on the reset edge.

Verification
REQ-033 SHALL cover a basic tone: ticks=100, half=50, dur=3 -> playing high for 300 cycles; sound toggles every 50 cycles, giving 6 toggles; note_done pulses once; sound = 0 afterwards.
REQ-034 SHALL cover a rest: ticks=100, half=0, dur=2 -> playing high for 200 cycles; sound constantly 0; note_done pulses once.
REQ-035 SHALL cover back-to-back notes with GAP_MS=10: note B is offered during note A -> B is accepted in A's first cycle; exactly 1000 silent cycles separate A's note_done and B's PLAY entry.
REQ-036 SHALL cover backpressure: a third note offered while one note is active and one is pending -> note_ready = 0 until the pending note loads; no note is lost and order is preserved.
REQ-037 SHALL cover edge values: dur=0 -> 1 cycle of PLAY and a note_done pulse; ticks=0 -> behaves as ticks=1, so dur=4 lasts 4 cycles.
REQ-038 SHALL cover reset mid-note: rst_n low for 1 cycle during PLAY -> IDLE, sound = 0, note_ready = 1 afterwards, and no note_done for the aborted note.
